// File: rtl/adder_arbiter_if.sv
// Requester and result bus of adder_arbiter.
// Valid/ready semantics for both directions: a transfer happens on a rising
// clock edge where valid and ready are both high; the producer keeps valid and
// its payload stable until that edge, and ready may depend combinationally on valid.
interface adder_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*33-1:0] req_ins;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [9:0]         out_sum;
    logic               out_zero;
    logic [IDW-1:0]     out_id;

    // Client side: drives requests and consumes results.
    modport master (
        output req_valid, req_ins, out_ready,
        input  req_ready, out_valid, out_sum, out_zero, out_id
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_ins, out_ready,
        output req_ready, out_valid, out_sum, out_zero, out_id
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between NREQ requesters.
// The granted operand word goes to the adder in the grant cycle, the adder
// result returns one cycle later and is queued, tagged with the requester id,
// in a small result FIFO that drains over a valid/ready output.
// Optional build macro ADDER_ARB_STATS_EN adds saturating grant_cnt and
// stall_cnt counters as extra output ports.
module adder_arbiter #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus,
    output logic [32:0]    add_ins,
    input  logic [9:0]     add_sm_r,
    input  logic           add_sm_zero_r
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]    grant_cnt,
    output logic [15:0]    stall_cnt
`endif
);
    localparam int OPW = 33;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    logic [IDW-1:0] rr_ptr;
    logic           inf_v;
    logic [IDW-1:0] inf_id;

    logic [9:0]     fifo_sum  [FIFO_DEPTH];
    logic           fifo_zero [FIFO_DEPTH];
    logic [IDW-1:0] fifo_id   [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           pop;
    logic           push;
    logic [CW:0]    occ;
    logic           issue_ok;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = inf_v;

    // Slots already committed after this cycle: queued entries minus the one
    // leaving now, plus the result still inside the adder. A new issue is only
    // allowed if it will find a free FIFO entry, so the FIFO can never overflow.
    assign occ      = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inf_v};
    assign issue_ok = (occ < (CW + 1)'(FIFO_DEPTH));

    // Round-robin search starting one past the last granted requester.
    always_comb begin : arb_search
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset also masks the grant so nothing is accepted while rst is high.
    assign issue = issue_ok & grant_found & ~rst;

    // One-hot grant and adder operand drive; both are zero on idle cycles.
    always_comb begin
        bus.req_ready = '0;
        add_ins       = '0;
        if (issue) begin
            bus.req_ready[grant_idx] = 1'b1;
            add_ins                  = bus.req_ins[OPW*int'(grant_idx) +: OPW];
        end
    end

    // Pointer and in-flight tracking; an in-flight result is discarded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IDW'(NREQ - 1);
            inf_v  <= 1'b0;
            inf_id <= '0;
        end else begin
            inf_v <= issue;
            if (issue) begin
                rr_ptr <= grant_idx;
                inf_id <= grant_idx;
            end
        end
    end

    // Result FIFO: the adder result is written in the cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_sum[i]  <= '0;
                fifo_zero[i] <= 1'b0;
                fifo_id[i]   <= '0;
            end
        end else begin
            if (push) begin
                fifo_sum[wr_ptr]  <= add_sm_r;
                fifo_zero[wr_ptr] <= add_sm_zero_r;
                fifo_id[wr_ptr]   <= inf_id;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Head entry presented from registers; forced to zero while the FIFO is empty.
    assign bus.out_sum  = bus.out_valid ? fifo_sum[rd_ptr]  : '0;
    assign bus.out_zero = bus.out_valid ? fifo_zero[rd_ptr] : 1'b0;
    assign bus.out_id   = bus.out_valid ? fifo_id[rd_ptr]   : '0;

`ifdef ADDER_ARB_STATS_EN
    // Saturating counters of issue cycles and of cycles blocked by a full pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue && grant_cnt != 16'hFFFF) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
            if ((|bus.req_valid) && !issue_ok && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: table-driven grant sequence, hand-written latency,
// reset and backpressure sequences, and a result scoreboard fed at accept time.
module tb_adder_arbiter;
    localparam int NREQ       = 4;
    localparam int IDW        = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int EW         = IDW + 11;
    localparam int NV         = 26;

    typedef struct packed {
        logic [NREQ-1:0] valid;
        logic            rdy;
        logic [NREQ-1:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] add_ins;
    logic [9:0]  add_sm_r;
    logic        add_sm_zero_r;
    logic [32:0] op [NREQ];
    logic        refresh [NREQ];
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    logic [EW-1:0]   exp_q [$];
    logic [EW-1:0]   exp_w;
    vec_t            vecs [NV];
    logic [NREQ-1:0] bp_exp [5];
    int checks  = 0;
    int passes  = 0;
    int max_out = 0;

    adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .add_ins       (add_ins),
        .add_sm_r      (add_sm_r),
        .add_sm_zero_r (add_sm_zero_r)
`ifdef ADDER_ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Stand-in adder arithmetic chosen to reproduce the reference vectors:
    // 33'h1_0302_010C -> 10, 33'h1_FFFF_FFFF -> 769, all zero -> 0.
    function automatic logic [9:0] adder_f(input logic [32:0] w);
        return 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]) + {7'd0, w[32], 2'b00};
    endfunction

    // Registered adder stand-in with one cycle of latency.
    always_ff @(posedge clk) begin
        add_sm_r      <= adder_f(add_ins);
        add_sm_zero_r <= (adder_f(add_ins) == 10'd0);
    end

    // Pack the per-requester operand words onto the bus.
    always_comb begin
        bus.req_ins = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ins[33*i +: 33] = op[i];
        end
    end

    function automatic logic [32:0] rand_word();
        return {1'($urandom_range(0, 1)), 32'($urandom)};
    endfunction

    function automatic vec_t mk(input logic [NREQ-1:0] v, input logic r, input logic [NREQ-1:0] e);
        vec_t t;
        t.valid = v;
        t.rdy   = r;
        t.exp   = e;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop on output transfer; flushed by reset.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    check("add_ins", 64'(add_ins), 64'(op[i]));
                    exp_q.push_back({IDW'(i), (adder_f(op[i]) == 10'd0), adder_f(op[i])});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_valid), 64'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_word", 64'({bus.out_id, bus.out_zero, bus.out_sum}), 64'(exp_w));
                end
            end
            if (exp_q.size() > max_out) begin
                max_out = exp_q.size();
            end
        end
    end

    // One request from a single requester on an idle arbiter, with exact latency.
    task automatic single(input int r, input logic [32:0] w, input logic [9:0] es, input logic ez);
        @(posedge clk); #1;
        op[r]         = w;
        bus.req_valid = NREQ'(1 << r);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("single_ready", 64'(bus.req_ready), 64'(NREQ'(1 << r)));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("lat_t1_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("lat_t2_valid", 64'(bus.out_valid), 64'(1));
        check("lat_t2_sum", 64'(bus.out_sum), 64'(es));
        check("lat_t2_zero", 64'(bus.out_zero), 64'(ez));
        check("lat_t2_id", 64'(bus.out_id), 64'(r));
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Grant sequence from reset (pointer at NREQ-1, FIFO empty)
        for (int r = 0; r < 6; r++) begin
            vecs[r] = mk(4'hF, 1'b1, NREQ'(1 << (r % NREQ)));
        end
        vecs[6]  = mk(4'h0, 1'b1, 4'h0);
        vecs[7]  = mk(4'h0, 1'b1, 4'h0);
        vecs[8]  = mk(4'hF, 1'b0, 4'h4);
        vecs[9]  = mk(4'hF, 1'b0, 4'h8);
        vecs[10] = mk(4'hF, 1'b0, 4'h0);
        vecs[11] = mk(4'hF, 1'b0, 4'h0);
        vecs[12] = mk(4'hF, 1'b0, 4'h0);
        vecs[13] = mk(4'hF, 1'b1, 4'h1);
        vecs[14] = mk(4'hF, 1'b1, 4'h2);
        vecs[15] = mk(4'hF, 1'b1, 4'h4);
        vecs[16] = mk(4'h0, 1'b1, 4'h0);
        vecs[17] = mk(4'h0, 1'b1, 4'h0);
        vecs[18] = mk(4'h3, 1'b1, 4'h1);
        vecs[19] = mk(4'h3, 1'b1, 4'h2);
        vecs[20] = mk(4'h9, 1'b1, 4'h8);
        vecs[21] = mk(4'h9, 1'b1, 4'h1);
        vecs[22] = mk(4'h4, 1'b1, 4'h4);
        vecs[23] = mk(4'h0, 1'b1, 4'h0);
        vecs[24] = mk(4'h0, 1'b1, 4'h0);
        vecs[25] = mk(4'h0, 1'b1, 4'h0);
        bp_exp[0] = 4'h1;
        bp_exp[1] = 4'h2;
        bp_exp[2] = 4'h0;
        bp_exp[3] = 4'h0;
        bp_exp[4] = 4'h0;

        // Reset with requests pending: nothing may be granted or driven
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op[i]      = rand_word();
            refresh[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_add_ins", 64'(add_ins), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_sum", 64'(bus.out_sum), 64'(0));
        check("rst_out_zero", 64'(bus.out_zero), 64'(0));
        check("rst_out_id", 64'(bus.out_id), 64'(0));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Table: round robin, backpressure, resume, sparse request patterns
        for (int r = 0; r < NV; r++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (refresh[i]) begin
                    op[i]      = rand_word();
                    refresh[i] = 1'b0;
                end
            end
            bus.req_valid = vecs[r].valid;
            bus.out_ready = vecs[r].rdy;
            @(negedge clk);
            check($sformatf("grant_row%0d", r), 64'(bus.req_ready), 64'(vecs[r].exp));
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    refresh[i] = 1'b1;
                end
            end
        end

        // Reference operand words
        single(0, 33'h1_0302_010C, 10'd10, 1'b0);
        single(2, 33'h0_0000_0000, 10'd0, 1'b1);
        single(1, 33'h1_FFFF_FFFF, 10'h301, 1'b0);

        // Reset with one result queued and one inside the adder
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0100;
        op[2]         = rand_word();
        @(negedge clk);
        check("rstmid_grant2", 64'(bus.req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
        op[3]         = rand_word();
        @(negedge clk);
        check("rstmid_grant3", 64'(bus.req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("rstmid_head_valid", 64'(bus.out_valid), 64'(1));
        check("rstmid_head_id", 64'(bus.out_id), 64'(2));
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_valid_drop", 64'(bus.out_valid), 64'(0));
        check("rstmid_sum_drop", 64'(bus.out_sum), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant0", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_grant1", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge clk);

        // Backpressure from reset: two grants, then stalls
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus.req_valid = '1;
            @(negedge clk);
            check($sformatf("bp_cycle%0d", c), 64'(bus.req_ready), 64'(bp_exp[c]));
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
`ifdef ADDER_ARB_STATS_EN
        check("stats_grant_cnt", 64'(grant_cnt), 64'(2));
        check("stats_stall_cnt", 64'(stall_cnt), 64'(3));
`endif
        check("bp_full_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);

        @(negedge clk);
        check("all_delivered", 64'(exp_q.size()), 64'(0));
        check("max_outstanding", 64'(max_out <= FIFO_DEPTH), 64'(1));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one `adder` datapath instance between NREQ requesters using round-robin arbitration.
- Each requester presents a packed 33-bit operand word: bits 7:0 s1.x, 15:8 s1.y, 23:16 s1.z, 31:24 s1.w, 32 cin.
- The block drives the adder input, tracks the single in-flight operation through the adder's 1-cycle registered result, and buffers tagged results in a small FIFO.
- Results leave on a valid/ready output. Sits between requester clients and the adder.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the requester id tag; must equal clog2(NREQ).
- FIFO_DEPTH, 2, result FIFO entries (2..8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ins  in  NREQ*33  operand words; requester i occupies bits [33*i+32:33*i].
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- add_ins  out  33  operand word to the adder `ins`.
- add_sm_r  in  10  adder registered sum.
- add_sm_zero_r  in  1  adder registered zero flag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  10  result sum.
- out_zero  out  1  result zero flag.
- out_id  out  IDW  index of the requester that produced the result.

Behaviour:
- Reset (async, rst=1):
  - Round-robin pointer is set to NREQ-1, so requester 0 has first priority.
  - In-flight flag, FIFO count and pointers are cleared.
  - out_valid=0, out_sum=0, out_zero=0, out_id=0, req_ready=0, add_ins=0.
  - A result in flight when reset asserts is dropped.
- Issue condition: issue_ok = (count - pop + inf_v) < FIFO_DEPTH, where pop = out_valid & out_ready and inf_v is the in-flight flag.
- Arbitration (combinational, same cycle):
  - Applies only when issue_ok is true.
  - Search starts at pointer+1 and wraps modulo NREQ; the first requester with req_valid set is granted.
  - req_ready is one-hot at the granted index, otherwise all zeros.
  - req_ready never asserts when issue_ok=0.
- Datapath drive:
  - On an issue cycle, add_ins = the granted requester's operand word; otherwise add_ins = 0.
  - Pointer updates to the granted index only on issue.
- In-flight tracking:
  - Issue in cycle t sets inf_v and inf_id for cycle t+1.
  - In cycle t+1, add_sm_r and add_sm_zero_r are valid; they are pushed into the FIFO at the end of t+1 together with inf_id.
- Latency: accept at cycle t gives out_valid no earlier than cycle t+2.
- Throughput: one result per cycle when out_ready is held at 1.
- FIFO:
  - Registered output; out_* show the head entry; out_valid = count != 0.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the issue rule; the bench asserts it never happens.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stability: while out_valid=1 and out_ready=0, out_sum, out_zero and out_id hold stable.
- A requester whose req_valid stays high without grant keeps its operand stable; fairness guarantee is grant within NREQ issue slots.
- Width: sums are the adder's 10-bit values passed through unmodified (maximum 769).

Optional Feature:
- Macro ADDER_ARB_STATS_EN adds two outputs:
  - grant_cnt[15:0]: increments on every issue.
  - stall_cnt[15:0]: increments every cycle where any req_valid=1 and issue_ok=0.
- Both counters saturate at 16'hFFFF and are cleared by rst.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single request: req_valid=4'b0001 for one cycle, ins=33'h1_0302_010C, out_ready=1 -> req_ready=4'b0001 at t; out_valid at t+2 with out_sum=10, out_zero=0, out_id=0.
- Round robin: all four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one per cycle; out_id follows the same order two cycles later.
- Zero result: ins=33'h0_0000_0000 from requester 2 -> out_sum=0, out_zero=1, out_id=2.
- Backpressure: out_ready=0, all valid -> exactly FIFO_DEPTH grants (2), then req_ready stays 0. Raising out_ready drains results in order and resumes one grant per cycle.
- Max value: ins=33'h1_FFFF_FFFF -> out_sum=769 (10'h301).
- Reset mid-operation: assert rst one cycle after an issue -> out_valid=0 immediately and the in-flight result is never delivered. After release, the first grant goes to requester 0.
- With ADDER_ARB_STATS_EN: the backpressure scenario gives grant_cnt=2 and stall_cnt = number of stalled cycles.
